// File: rtl/psram_async_responder.sv
// Stand-in for the external 16-bit async PSRAM: stores words, answers reads after a programmed
// access time and flags bus protocol violations. Define PSRAM_RESP_INIT_EN to preload mem[i] = i ^ 16'hA5A5.
module psram_async_responder #(
  parameter int ADDR_BITS     = 10,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        Clock,
  input  logic        Resetb,
  input  logic        CE,
  input  logic        WE,
  input  logic        OE,
  input  logic        ADV,
  input  logic        CRE,
  input  logic        UB,
  input  logic        LB,
  input  logic [23:0] AD,
  input  logic [15:0] DQin,
  output logic [15:0] DQout,
  output logic        DQoe,
  output logic        Busy,
  output logic        ReadDone,
  output logic        WriteDone,
  output logic        Error,
  output logic [1:0]  ErrCode
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ACC  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_ACC  = 3'd3;
  localparam logic [2:0] WR_ARM  = 3'd4;
  localparam logic [2:0] ABORT   = 3'd5;

  localparam logic [1:0] ERR_RD  = 2'b01;
  localparam logic [1:0] ERR_WR  = 2'b10;
  localparam logic [1:0] ERR_CRE = 2'b11;

  localparam int             CW       = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(ACCESS_CYCLES - 1);
  localparam bit             SINGLE   = (ACCESS_CYCLES == 1);

  logic                 s_ce, s_we, s_oe, s_cre, s_ub, s_lb;
  logic [ADDR_BITS-1:0] s_ad;
  logic [15:0]          s_dq;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] raddr, waddr;
  logic [15:0]          wdata;
  logic                 wub, wlb;

  logic [15:0] mem [0:(2**ADDR_BITS)-1];

  logic rd_release, wr_release, ad_changed, commit;
  logic unused_pins;

`ifdef PSRAM_RESP_INIT_EN
  initial begin
    for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] = 16'(i) ^ 16'hA5A5;
  end
`endif

  // Every bus pin passes through one register; the FSM only ever looks at these copies.
  always_ff @(posedge Clock) begin
    if (Resetb) begin
      s_ce  <= 1'b1;
      s_we  <= 1'b1;
      s_oe  <= 1'b1;
      s_cre <= 1'b0;
      s_ub  <= 1'b1;
      s_lb  <= 1'b1;
      s_ad  <= '0;
      s_dq  <= '0;
    end else begin
      s_ce  <= CE;
      s_we  <= WE;
      s_oe  <= OE;
      s_cre <= CRE;
      s_ub  <= UB;
      s_lb  <= LB;
      s_ad  <= AD[ADDR_BITS:1];
      s_dq  <= DQin;
    end
  end

  assign rd_release  = s_ce | s_oe;
  assign wr_release  = s_ce | s_we;
  assign ad_changed  = (s_ad != raddr);
  assign commit      = (state == WR_ARM) && wr_release && !Resetb;
  assign Busy        = (state != IDLE);
  assign unused_pins = ^{ADV, AD[23:ADDR_BITS+1], AD[0]};

  // cnt holds the number of low cycles already seen, so the cycle that enters an access counts as one.
  always_ff @(posedge Clock) begin
    if (Resetb) begin
      state     <= IDLE;
      cnt       <= '0;
      DQout     <= '0;
      DQoe      <= 1'b0;
      ReadDone  <= 1'b0;
      WriteDone <= 1'b0;
      Error     <= 1'b0;
      ErrCode   <= 2'b00;
      raddr     <= '0;
      waddr     <= '0;
      wdata     <= '0;
      wub       <= 1'b1;
      wlb       <= 1'b1;
    end else begin
      ReadDone  <= 1'b0;
      WriteDone <= 1'b0;
      case (state)
        IDLE: begin
          if (!s_ce) begin
            if (s_cre) begin
              if (!Error) begin
                Error   <= 1'b1;
                ErrCode <= ERR_CRE;
              end
              state <= ABORT;
            end else if (!s_we) begin
              wdata <= s_dq;
              waddr <= s_ad;
              wub   <= s_ub;
              wlb   <= s_lb;
              cnt   <= CNT_ONE;
              state <= SINGLE ? WR_ARM : WR_ACC;
            end else if (!s_oe) begin
              raddr <= s_ad;
              cnt   <= CNT_ONE;
              if (SINGLE) begin
                DQout    <= mem[s_ad];
                DQoe     <= 1'b1;
                ReadDone <= 1'b1;
                state    <= RD_DATA;
              end else begin
                state <= RD_ACC;
              end
            end
          end
        end
        RD_ACC: begin
          if (rd_release) begin
            if (!Error) begin
              Error   <= 1'b1;
              ErrCode <= ERR_RD;
            end
            state <= IDLE;
          end else if (ad_changed) begin
            raddr <= s_ad;
            cnt   <= CNT_ONE;
          end else if (cnt >= CNT_LAST) begin
            DQout    <= mem[s_ad];
            DQoe     <= 1'b1;
            ReadDone <= 1'b1;
            state    <= RD_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RD_DATA: begin
          if (rd_release) begin
            DQoe  <= 1'b0;
            DQout <= '0;
            state <= IDLE;
          end else if (ad_changed) begin
            DQoe  <= 1'b0;
            raddr <= s_ad;
            cnt   <= CNT_ONE;
            state <= RD_ACC;
          end
        end
        WR_ACC: begin
          if (wr_release) begin
            if (!Error) begin
              Error   <= 1'b1;
              ErrCode <= ERR_WR;
            end
            state <= IDLE;
          end else begin
            wdata <= s_dq;
            waddr <= s_ad;
            wub   <= s_ub;
            wlb   <= s_lb;
            if (cnt >= CNT_LAST) state <= WR_ARM;
            else                 cnt   <= cnt + CNT_ONE;
          end
        end
        WR_ARM: begin
          // The release cycle carries no data; the commit uses what was latched on the last low cycle.
          if (wr_release) begin
            WriteDone <= 1'b1;
            state     <= IDLE;
          end else begin
            wdata <= s_dq;
            waddr <= s_ad;
            wub   <= s_ub;
            wlb   <= s_lb;
          end
        end
        ABORT: begin
          if (s_ce) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (commit) begin
      if (!wub) mem[waddr][15:8] <= wdata[15:8];
      if (!wlb) mem[waddr][7:0]  <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_psram_async_responder.sv
// Scoreboard bench for psram_async_responder (ACCESS_CYCLES=3, ADDR_BITS=10).
// Works with or without PSRAM_RESP_INIT_EN; the model mirrors the preload when it is defined.
module tb_psram_async_responder;

  localparam int AC = 3;

  logic        Clock = 1'b0;
  logic        Resetb, CE, WE, OE, ADV, CRE, UB, LB;
  logic [23:0] AD;
  logic [15:0] DQin;
  logic [15:0] DQout;
  logic        DQoe, Busy, ReadDone, WriteDone, Error;
  logic [1:0]  ErrCode;

  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic [15:0] model [0:1023];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];

  psram_async_responder #(.ADDR_BITS(10), .ACCESS_CYCLES(AC)) dut (
    .Clock(Clock), .Resetb(Resetb), .CE(CE), .WE(WE), .OE(OE), .ADV(ADV), .CRE(CRE),
    .UB(UB), .LB(LB), .AD(AD), .DQin(DQin), .DQout(DQout), .DQoe(DQoe), .Busy(Busy),
    .ReadDone(ReadDone), .WriteDone(WriteDone), .Error(Error), .ErrCode(ErrCode)
  );

  always #10 Clock = ~Clock;

  // Read data is captured into the scoreboard whenever the responder announces it.
  always @(negedge Clock) begin
    if (ReadDone) begin
      obs_q.push_back(DQout);
      rd_pulses++;
    end
    if (WriteDone) wr_pulses++;
  end

  function automatic logic [9:0] widx(input logic [23:0] a);
    return a[10:1];
  endfunction

  task automatic bus_idle();
    CE = 1'b1; WE = 1'b1; OE = 1'b1; ADV = 1'b0; CRE = 1'b0; UB = 1'b0; LB = 1'b0;
  endtask

  task automatic drive_write(input logic [23:0] addr, input logic [15:0] data,
                             input logic ub, input logic lb, input int hold);
    @(negedge Clock);
    AD = addr; DQin = data; UB = ub; LB = lb; CE = 1'b0; WE = 1'b0;
    repeat (hold) @(negedge Clock);
    CE = 1'b1; WE = 1'b1;
    if (hold >= AC) begin
      if (!ub) model[widx(addr)][15:8] = data[15:8];
      if (!lb) model[widx(addr)][7:0]  = data[7:0];
    end
    repeat (4) @(negedge Clock);
    UB = 1'b0; LB = 1'b0;
  endtask

  task automatic drive_read(input logic [23:0] addr, input int hold);
    @(negedge Clock);
    AD = addr; CE = 1'b0; OE = 1'b0;
    if (hold >= AC) exp_q.push_back(model[widx(addr)]);
    repeat (hold) @(negedge Clock);
    CE = 1'b1; OE = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_reset();
    bus_idle(); AD = '0; DQin = '0;
    Resetb = 1'b1;
    repeat (3) @(negedge Clock);
    checks++; if (DQout !== 16'h0)    begin errors++; $display("[TB] FAIL reset_dqout got %h want 0000", DQout); end
    checks++; if (DQoe !== 1'b0)      begin errors++; $display("[TB] FAIL reset_dqoe got %b want 0", DQoe); end
    checks++; if (Busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    checks++; if (ReadDone !== 1'b0)  begin errors++; $display("[TB] FAIL reset_readdone got %b want 0", ReadDone); end
    checks++; if (WriteDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_writedone got %b want 0", WriteDone); end
    checks++; if (Error !== 1'b0)     begin errors++; $display("[TB] FAIL reset_error got %b want 0", Error); end
    checks++; if (ErrCode !== 2'b00)  begin errors++; $display("[TB] FAIL reset_errcode got %b want 00", ErrCode); end
    Resetb = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_read_unwritten();
    int rd0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    rd0 = rd_pulses;
    @(negedge Clock);
    AD = 24'h000010; CE = 1'b0; OE = 1'b0;
    exp_q.push_back(model[widx(24'h000010)]);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      checks++;
      if (DQoe !== (k >= AC + 1)) begin
        errors++; $display("[TB] FAIL read_latency_edge%0d got %b want %b", k, DQoe, (k >= AC + 1));
      end
      if (k == 2) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy got %b want 1", Busy); end
      end
    end
    CE = 1'b1; OE = 1'b1;
    repeat (4) @(negedge Clock);
    checks++; if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL read_pulses got %0d want 1", rd_pulses - rd0); end
    checks++; if (DQoe !== 1'b0) begin errors++; $display("[TB] FAIL read_release_dqoe got %b want 0", DQoe); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL read_unwritten_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_write_read();
    int wr0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    wr0 = wr_pulses;
    drive_write(24'h000020, 16'h1234, 1'b0, 1'b0, 5);
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("[TB] FAIL write_pulses got %0d want 1", wr_pulses - wr0); end
    drive_read(24'h000020, 5);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL wr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL write_read_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_byte_lanes();
    int wr0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    wr0 = wr_pulses;
    drive_write(24'h000020, 16'hBEEF, 1'b1, 1'b0, 5);
    drive_write(24'h000020, 16'h0000, 1'b1, 1'b1, 5);
    checks++; if (wr_pulses - wr0 != 2) begin errors++; $display("[TB] FAIL lane_pulses got %0d want 2", wr_pulses - wr0); end
    drive_read(24'h000020, 5);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL lane_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL lane_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_early_abort();
    int wr0, rd0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    wr0 = wr_pulses;
    drive_write(24'h000020, 16'h5555, 1'b0, 1'b0, AC - 1);
    checks++; if (wr_pulses - wr0 != 0) begin errors++; $display("[TB] FAIL abort_wr_pulses got %0d want 0", wr_pulses - wr0); end
    checks++; if (Error !== 1'b1)      begin errors++; $display("[TB] FAIL abort_error got %b want 1", Error); end
    checks++; if (ErrCode !== 2'b10)   begin errors++; $display("[TB] FAIL abort_errcode got %b want 10", ErrCode); end
    rd0 = rd_pulses;
    drive_read(24'h000020, 1);
    checks++; if (rd_pulses - rd0 != 0) begin errors++; $display("[TB] FAIL abort_rd_pulses got %0d want 0", rd_pulses - rd0); end
    checks++; if (ErrCode !== 2'b10)    begin errors++; $display("[TB] FAIL abort_sticky got %b want 10", ErrCode); end
    drive_read(24'h000020, 5);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL abort_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL abort_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_cre();
    logic oe_seen;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    Resetb = 1'b1; @(negedge Clock); Resetb = 1'b0; @(negedge Clock);
    checks++; if (Error !== 1'b0) begin errors++; $display("[TB] FAIL cre_pre_error got %b want 0", Error); end
    oe_seen = 1'b0;
    AD = 24'h000020; CRE = 1'b1; CE = 1'b0; OE = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      if (DQoe !== 1'b0) oe_seen = 1'b1;
    end
    checks++; if (oe_seen !== 1'b0)  begin errors++; $display("[TB] FAIL cre_dqoe got %b want 0", oe_seen); end
    checks++; if (Busy !== 1'b1)     begin errors++; $display("[TB] FAIL cre_busy got %b want 1", Busy); end
    checks++; if (Error !== 1'b1)    begin errors++; $display("[TB] FAIL cre_error got %b want 1", Error); end
    checks++; if (ErrCode !== 2'b11) begin errors++; $display("[TB] FAIL cre_errcode got %b want 11", ErrCode); end
    CE = 1'b1; OE = 1'b1; CRE = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL cre_release_busy got %b want 0", Busy); end
    Resetb = 1'b1; @(negedge Clock); Resetb = 1'b0; @(negedge Clock);
    checks++; if (Error !== 1'b0 || ErrCode !== 2'b00) begin
      errors++; $display("[TB] FAIL cre_reset_clear got %b/%b want 0/00", Error, ErrCode);
    end
    drive_read(24'h000020, 5);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL cre_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL cre_keep_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_addr_change();
    logic dropped;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    @(negedge Clock);
    AD = 24'h000010; CE = 1'b0; OE = 1'b0;
    exp_q.push_back(model[widx(24'h000010)]);
    repeat (6) @(negedge Clock);
    checks++; if (DQoe !== 1'b1) begin errors++; $display("[TB] FAIL addr_first_dqoe got %b want 1", DQoe); end
    AD = 24'h000012;
    exp_q.push_back(model[widx(24'h000012)]);
    dropped = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (k == 2) begin
        checks++; if (DQoe !== 1'b0) begin errors++; $display("[TB] FAIL addr_drop got %b want 0", DQoe); end
      end
      if (DQoe === 1'b0) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1 || DQoe !== 1'b1) begin
      errors++; $display("[TB] FAIL addr_return got drop=%b dqoe=%b want 1/1", dropped, DQoe);
    end
    CE = 1'b1; OE = 1'b1;
    repeat (4) @(negedge Clock);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL addr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL addr_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int wr0, rd0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    wr0 = wr_pulses; rd0 = rd_pulses;
    @(negedge Clock);
    AD = 24'h000030; DQin = 16'hCAFE; UB = 1'b0; LB = 1'b0; CE = 1'b0; WE = 1'b0;
    repeat (AC) @(negedge Clock);
    CE = 1'b1; WE = 1'b1;
    model[widx(24'h000030)] = 16'hCAFE;
    @(negedge Clock);
    CE = 1'b0; OE = 1'b0;
    exp_q.push_back(model[widx(24'h000030)]);
    repeat (5) @(negedge Clock);
    CE = 1'b1; OE = 1'b1;
    repeat (4) @(negedge Clock);
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("[TB] FAIL b2b_wr_pulses got %0d want 1", wr_pulses - wr0); end
    checks++; if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL b2b_rd_pulses got %0d want 1", rd_pulses - rd0); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_write();
    int wr0;
    logic [15:0] e, o;
    exp_q.delete(); obs_q.delete();
    drive_write(24'h000040, 16'h1111, 1'b0, 1'b0, 5);
    wr0 = wr_pulses;
    @(negedge Clock);
    AD = 24'h000040; DQin = 16'h2222; CE = 1'b0; WE = 1'b0;
    repeat (AC + 1) @(negedge Clock);
    checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before got %b want 1", Busy); end
    Resetb = 1'b1; CE = 1'b1; WE = 1'b1;
    @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_after got %b want 0", Busy); end
    Resetb = 1'b0;
    repeat (4) @(negedge Clock);
    checks++; if (wr_pulses - wr0 != 0) begin errors++; $display("[TB] FAIL midrst_wr_pulses got %0d want 0", wr_pulses - wr0); end
    drive_read(24'h000040, 5);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL midrst_data got %h want %h", o, e); end
    end
  endtask

  initial begin
`ifdef PSRAM_RESP_INIT_EN
    for (int i = 0; i < 1024; i++) model[i] = 16'(i) ^ 16'hA5A5;
`endif
    test_reset();
`ifndef PSRAM_RESP_INIT_EN
    // Without a preload the "unwritten" words get the values a preload would have given them.
    drive_write(24'h000010, 16'(widx(24'h000010)) ^ 16'hA5A5, 1'b0, 1'b0, 5);
    drive_write(24'h000012, 16'(widx(24'h000012)) ^ 16'hA5A5, 1'b0, 1'b0, 5);
`endif
    test_read_unwritten();
    test_write_read();
    test_byte_lanes();
    test_early_abort();
    test_cre();
    test_addr_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
